// File: rtl/stopwatch_timer.sv
`default_nettype none
`timescale 1ns/1ps

// ============================================================================
// Module   : stopwatch_timer
// Purpose  : BCD hh:mm:ss.cc stopwatch / countdown timer with lap freeze and
//            an 8-digit multiplexed seven-segment display driver.
// Revision : 1.0 - initial release
// ============================================================================

module stopwatch_timer #(
    parameter int TICK_DIV = 10,
    parameter int HOUR_MAX = 23,
    parameter int SCAN_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        lap,
    input  logic        mode,
    input  logic        load,
    input  logic [23:0] preset,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_com,
    output logic        running,
    output logic        done
);

    localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [3:0] c_H_TEN = 4'(HOUR_MAX / 10);
    localparam logic [3:0] c_H_ONE = 4'(HOUR_MAX % 10);
    localparam logic [6:0] c_H_MAX = 7'(HOUR_MAX);

    // Digit index 0..7 = h_ten, h_one, m_ten, m_one, s_ten, s_one, c_ten, c_one
    logic [3:0]           r_dig  [0:7];
    logic [3:0]           r_snap [0:7];
    logic                 r_start_q, r_lap_q, r_load_q;
    logic                 r_running, r_done, r_dir, r_freeze;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_SCAN_W-1:0]  r_scan_div;
    logic [2:0]           r_k;
    logic [7:0]           r_seg_data, r_seg_com;

    logic [3:0] w_up [0:7];
    logic [3:0] w_dn [0:7];
    logic [3:0] w_ld [0:7];
    logic       w_start_edge, w_lap_edge, w_load_edge, w_load_ok;
    logic       w_tick, w_zero, w_dn_zero, w_start_sets, w_hit_zero;
    logic [3:0] w_ph_ten, w_ph_one;
    logic [6:0] w_hval;

    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 2 || idx == 4) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_start_edge = start & ~r_start_q;
    assign w_lap_edge   = lap   & ~r_lap_q;
    assign w_load_edge  = load  & ~r_load_q;
    assign w_load_ok    = w_load_edge & ~r_running;
    assign w_tick       = r_running & (r_presc == c_PRESC_LAST);
    assign w_start_sets = w_start_edge & ~r_running & ~(mode & w_zero);
    assign w_hit_zero   = w_tick & r_dir & w_dn_zero;

    always_comb begin : p_zero
        w_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (r_dig[i] != 4'd0) w_zero = 1'b0;
        end
    end

    always_comb begin : p_up
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) w_up[i] = r_dig[i];
        for (int i = 7; i >= 2; i--) begin
            if (carry) begin
                if (r_dig[i] == digit_max(i)) begin
                    w_up[i] = 4'd0;
                end else begin
                    w_up[i] = r_dig[i] + 4'd1;
                    carry   = 1'b0;
                end
            end
        end
        // Hours wrap on the configured maximum rather than on a digit limit
        if (carry) begin
            if (r_dig[0] == c_H_TEN && r_dig[1] == c_H_ONE) begin
                w_up[0] = 4'd0;
                w_up[1] = 4'd0;
            end else if (r_dig[1] == 4'd9) begin
                w_up[0] = r_dig[0] + 4'd1;
                w_up[1] = 4'd0;
            end else begin
                w_up[1] = r_dig[1] + 4'd1;
            end
        end
    end

    always_comb begin : p_down
        logic       borrow;
        logic [3:0] d;
        borrow    = ~w_zero;
        w_dn_zero = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            d = r_dig[i];
            if (borrow) begin
                if (r_dig[i] == 4'd0) begin
                    d = digit_max(i);
                end else begin
                    d      = r_dig[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
            w_dn[i] = d;
            if (d != 4'd0) w_dn_zero = 1'b0;
        end
    end

    assign w_ph_ten = sat_digit(preset[23:20], 4'd9);
    assign w_ph_one = sat_digit(preset[19:16], 4'd9);
    assign w_hval   = 7'(w_ph_ten) * 7'd10 + 7'(w_ph_one);
    assign w_ld[0]  = (w_hval > c_H_MAX) ? c_H_TEN : w_ph_ten;
    assign w_ld[1]  = (w_hval > c_H_MAX) ? c_H_ONE : w_ph_one;
    assign w_ld[2]  = sat_digit(preset[15:12], 4'd5);
    assign w_ld[3]  = sat_digit(preset[11:8],  4'd9);
    assign w_ld[4]  = sat_digit(preset[7:4],   4'd5);
    assign w_ld[5]  = sat_digit(preset[3:0],   4'd9);
    assign w_ld[6]  = 4'd0;
    assign w_ld[7]  = 4'd0;

    always_ff @(posedge clk or negedge rst) begin : p_edges
        if (!rst) begin
            r_start_q <= 1'b0;
            r_lap_q   <= 1'b0;
            r_load_q  <= 1'b0;
        end else begin
            r_start_q <= start;
            r_lap_q   <= lap;
            r_load_q  <= load;
        end
    end

    // All edge effects below are judged against the pre-edge running state
    always_ff @(posedge clk or negedge rst) begin : p_count
        if (!rst) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_dir     <= 1'b0;
            r_presc   <= '0;
            for (int i = 0; i < 8; i++) r_dig[i] <= 4'd0;
        end else begin
            if (w_load_ok) begin
                r_presc <= '0;
            end else if (r_running) begin
                r_presc <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
            end

            if (w_load_ok) begin
                r_dig <= w_ld;
            end else if (w_tick) begin
                if (r_dir) r_dig <= w_dn;
                else       r_dig <= w_up;
            end

            if (w_hit_zero || (w_start_edge && r_running)) begin
                r_running <= 1'b0;
            end else if (w_start_sets) begin
                r_running <= 1'b1;
            end

            if (w_start_sets) r_dir <= mode;

            if (w_hit_zero) begin
                r_done <= 1'b1;
            end else if (w_load_edge || w_start_sets) begin
                r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin : p_snapshot
        if (!rst) begin
            r_freeze <= 1'b0;
            for (int i = 0; i < 8; i++) r_snap[i] <= 4'd0;
        end else begin
            if (w_lap_edge) r_freeze <= r_running ? ~r_freeze : 1'b0;
            if (!r_freeze) r_snap <= r_dig;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : p_scan
        if (!rst) begin
            r_scan_div <= '0;
            r_k        <= 3'd0;
            r_seg_com  <= 8'hFF;
            r_seg_data <= 8'h00;
        end else begin
            if (r_scan_div == c_SCAN_LAST) begin
                r_scan_div <= '0;
                r_k        <= r_k + 3'd1;
            end else begin
                r_scan_div <= r_scan_div + c_SCAN_W'(1);
            end
            r_seg_com  <= ~(8'h80 >> r_k);
            r_seg_data <= {(r_k == 3'd1 || r_k == 3'd3 || r_k == 3'd5), seg7(r_snap[r_k])};
        end
    end

    assign seg_data = r_seg_data;
    assign seg_com  = r_seg_com;
    assign running  = r_running;
    assign done     = r_done;

endmodule

`default_nettype wire
